// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receiver and transmitter:
//   - default oversampling divider and stop-bit tick count
//   - receiver FSM state encoding (localparams plus the enum built on them)
// -----------------------------------------------------------------------------
package uart_pkg;

  // 100 MHz / (115200 * 16) ~= 54 clk per oversampling tick.
  localparam int DIV_DEFAULT     = 54;
  // 16 ticks in the stop bit = one stop bit.
  localparam int SB_TICK_DEFAULT = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP,
    BREAK = ST_BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Free-running oversampling tick generator. Counts 0..DIV-1 and raises tick
// for the single cycle in which the count equals DIV-1.
// Ports:
//   clk  in  clock
//   rst  in  synchronous active-high reset (count returns to 0)
//   tick out one-cycle pulse every DIV clk cycles
// -----------------------------------------------------------------------------
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT  // must be >= 2
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  // NOTE: clocked state is always assigned with <= so every register samples
  // the pre-edge values of its inputs, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// Oversampling 8N1 UART receiver. The asynchronous line is brought in through a
// 2-FF synchroniser, a start bit is confirmed at its middle, data bits are
// sampled at mid-bit (LSB first) and the stop bit is checked before the byte is
// published.
// Ports:
//   clk          in  clock
//   rst          in  synchronous active-high reset
//   rx           in  asynchronous serial line, idle high
//   rx_done_tick out one-cycle pulse, dout holds a newly received byte
//   dout         out last correctly framed byte, held until the next one
//   frame_err    out one-cycle pulse, stop bit was sampled low
//   busy         out receiver FSM is not idle
// -----------------------------------------------------------------------------
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = SB_TICK_DEFAULT,
  parameter int DIV     = DIV_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            frame_err,
  output logic            busy
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  logic            s_tick;
  logic [1:0]      sync_q;
  logic            rx_s;

  rx_state_t       state_q, state_d;
  logic [3:0]      s_cnt_q, s_cnt_d;
  logic [NW-1:0]   n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_d;
  logic            done_d, err_d;

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .tick (s_tick)
  );

  // Synchroniser resets to the idle (high) level so reset never looks like a
  // start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rx_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      s_cnt_q      <= '0;
      n_cnt_q      <= '0;
      b_q          <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_cnt_q      <= s_cnt_d;
      n_cnt_q      <= n_cnt_d;
      b_q          <= b_d;
      dout         <= dout_d;
      rx_done_tick <= done_d;
      frame_err    <= err_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    b_d     = b_q;
    dout_d  = dout;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // Start detection is not gated by s_tick, so it is 1 clk after rx_s.
        if (!rx_s) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end

      START: begin
        if (s_tick) begin
          if (s_cnt_q == 4'd7) begin
            if (!rx_s) begin
              state_d = DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = IDLE;  // line went high before mid start bit: glitch
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == 4'd15) begin
            s_cnt_d = '0;
            b_d     = {rx_s, b_q[DBIT-1:1]};  // LSB arrives first
            if (n_cnt_q == NW'(DBIT - 1)) begin
              state_d = STOP;
            end else begin
              n_cnt_d = n_cnt_q + NW'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end

      STOP: begin
        if (s_tick) begin
          if (s_cnt_q == 4'(SB_TICK - 1)) begin
            if (rx_s) begin
              dout_d  = b_q;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = BREAK;
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end

      BREAK: begin
        // A line held low must return high before a new start is accepted.
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
// Directed bench for uart_rx_core with DIV=4 (one bit = 64 clk). A monitor
// counts rx_done_tick / frame_err pulses on the falling edge and records dout
// at each done pulse; the main sequence compares against hand-computed values.
// -----------------------------------------------------------------------------
module tb_uart_rx_core;

  localparam int DIV = 4;
  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx_core #(
    .DBIT    (8),
    .SB_TICK (16),
    .DIV     (DIV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_done_tick (rx_done_tick),
    .dout         (dout),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int         done_cnt   = 0;
  int         err_cnt    = 0;
  int         pulse_viol = 0;
  logic [7:0] cap [0:31];
  logic       prev_done  = 1'b0;
  logic       prev_err   = 1'b0;

  // Pulse monitor: outputs sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_done_tick === 1'b1) begin
      cap[done_cnt % 32] = dout;
      done_cnt++;
    end
    if (frame_err === 1'b1) err_cnt++;
    if ((rx_done_tick && prev_done) || (frame_err && prev_err) ||
        (rx_done_tick && frame_err))
      pulse_viol++;
    prev_done = rx_done_tick;
    prev_err  = frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic v, input int len);
    rx = v;
    wait_clk(len);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop, input int len);
    send_bit(1'b0, len);
    for (int i = 0; i < 8; i++) send_bit(d[i], len);
    send_bit(stop, len);
  endtask

  int d0, e0;

  initial begin
    rst = 1'b1;
    rx  = 1'b1;

    // Reset state
    wait_clk(4);
    check("rst_dout", 32'(dout), 32'h00);
    check("rst_done", 32'(rx_done_tick), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    wait_clk(4);
    check("idle_busy", 32'(busy), 32'h0);

    // Single byte 0xA5
    send_byte(8'hA5, 1'b1, BIT);
    wait_clk(BIT);
    check("a5_done_cnt", 32'(done_cnt), 32'd1);
    check("a5_cap", 32'(cap[0]), 32'hA5);
    check("a5_dout", 32'(dout), 32'hA5);
    check("a5_ferr_cnt", 32'(err_cnt), 32'd0);
    check("a5_busy", 32'(busy), 32'h0);

    // Start glitch: 12 clk low
    d0 = done_cnt; e0 = err_cnt;
    rx = 1'b0;
    wait_clk(12);
    check("glitch_busy_start", 32'(busy), 32'h1);
    rx = 1'b1;
    wait_clk(40);
    check("glitch_busy_idle", 32'(busy), 32'h0);
    check("glitch_done_cnt", 32'(done_cnt), 32'(d0));
    check("glitch_ferr_cnt", 32'(err_cnt), 32'(e0));

    // Framing error on 0x3C, line then held low (break)
    send_byte(8'h3C, 1'b0, BIT);
    wait_clk(200);
    check("ferr_cnt", 32'(err_cnt), 32'(e0 + 1));
    check("ferr_done_cnt", 32'(done_cnt), 32'(d0));
    check("ferr_dout_kept", 32'(dout), 32'hA5);
    check("ferr_busy_break", 32'(busy), 32'h1);
    rx = 1'b1;
    wait_clk(BIT);
    check("break_release_busy", 32'(busy), 32'h0);
    send_byte(8'h5A, 1'b1, BIT);
    wait_clk(BIT);
    check("5a_done_cnt", 32'(done_cnt), 32'(d0 + 1));
    check("5a_dout", 32'(dout), 32'h5A);
    check("5a_ferr_cnt", 32'(err_cnt), 32'(e0 + 1));

    // Back-to-back 0x00 then 0xFF, one stop bit, no gap
    d0 = done_cnt;
    send_byte(8'h00, 1'b1, BIT);
    send_byte(8'hFF, 1'b1, BIT);
    wait_clk(BIT);
    check("b2b_done_cnt", 32'(done_cnt), 32'(d0 + 2));
    check("b2b_cap0", 32'(cap[d0 % 32]), 32'h00);
    check("b2b_cap1", 32'(cap[(d0 + 1) % 32]), 32'hFF);
    check("b2b_dout", 32'(dout), 32'hFF);

    // Reset in the middle of bit 4 of 0x81; the sender abandons the frame
    d0 = done_cnt; e0 = err_cnt;
    send_bit(1'b0, BIT);                          // start
    send_bit(1'b1, BIT);                          // bit 0
    send_bit(1'b0, BIT);                          // bit 1
    send_bit(1'b0, BIT);                          // bit 2
    send_bit(1'b0, BIT);                          // bit 3
    send_bit(1'b0, BIT / 2);                      // first half of bit 4
    check("mid_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    rx  = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    check("mrst_dout", 32'(dout), 32'h00);
    check("mrst_busy", 32'(busy), 32'h0);
    wait_clk(10 * BIT);
    check("mrst_done_cnt", 32'(done_cnt), 32'(d0));
    check("mrst_ferr_cnt", 32'(err_cnt), 32'(e0));
    check("mrst_dout_idle", 32'(dout), 32'h00);
    send_byte(8'h42, 1'b1, BIT);
    wait_clk(BIT);
    check("42_done_cnt", 32'(done_cnt), 32'(d0 + 1));
    check("42_dout", 32'(dout), 32'h42);

    // Line 3% fast: 62 clk per bit
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hC3, 1'b1, 62);
    wait_clk(BIT);
    check("fast_done_cnt", 32'(done_cnt), 32'(d0 + 1));
    check("fast_dout", 32'(dout), 32'hC3);
    check("fast_ferr_cnt", 32'(err_cnt), 32'(e0));

    // Pulses were single-cycle and never overlapped
    check("pulse_shape", 32'(pulse_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Oversampling UART receiver: synchronises the asynchronous `rx` line, detects start bits, samples 8N1 frames at mid-bit using a 16× baud tick, and emits each received byte with a one-cycle `rx_done_tick`. It sits directly upstream of the RX flag/buffer interface: `rx_done_tick` drives that stage's `set_flag`, and `dout` drives its `data_in`. Framing errors are reported separately and never produce a done tick.

## Interface

Parameters:
- `DBIT`, 8 — data bits per frame, LSB first.
- `SB_TICK`, 16 — oversampling ticks spent in the stop bit before it is sampled (16 = one stop bit).
- `DIV`, 54 — clk cycles per oversampling tick (100 MHz / (115200·16) ≈ 54); legal range ≥ 2.

Ports:
- `clk` in 1 — clock.
- `rst` in 1 — reset, synchronous, active-high.
- `rx` in 1 — asynchronous serial line, idle high.
- `rx_done_tick` out 1 — one-cycle pulse: a valid byte is on `dout`.
- `dout` out DBIT — last correctly framed byte; held until the next one.
- `frame_err` out 1 — one-cycle pulse: stop bit sampled low.
- `busy` out 1 — high whenever the FSM is not in IDLE.

## Operation

- `rx` passes through a 2-FF synchroniser; the FSM sees only `rx_s`. The synchroniser resets to 1.
- Tick generator: counter 0..DIV-1, free-running. `s_tick` is high for the one cycle where counter == DIV-1.
- FSM states: IDLE, START, DATA, STOP, BREAK. Tick counter `s_cnt` is 4 bits; bit counter `n_cnt` is 3 bits (sized for DBIT).
- IDLE, `rx_s`==0: go to START and clear `s_cnt`. This check does not wait for `s_tick`.
- START: on each `s_tick`, increment `s_cnt`. At `s_cnt`==7 (mid start bit):
  - `rx_s`==0: go to DATA and clear `s_cnt`, `n_cnt`.
  - `rx_s`==1: glitch; return to IDLE. No output.
- DATA: on each `s_tick`, increment `s_cnt`. At `s_cnt`==15:
  - Shift `rx_s` into the MSB of the shift register (right shift) and clear `s_cnt`.
  - If `n_cnt`==DBIT-1, go to STOP; otherwise increment `n_cnt`.
- STOP: on each `s_tick`, increment `s_cnt`. At `s_cnt`==SB_TICK-1:
  - `rx_s`==1: load `dout` from the shift register, pulse `rx_done_tick`, go to IDLE.
  - `rx_s`==0: pulse `frame_err`, leave `dout` unchanged, go to BREAK.
- BREAK: wait for `rx_s`==1, then go to IDLE. This prevents a held-low line from re-triggering.
- `rx_done_tick` and `frame_err` are mutually exclusive and never assert for more than one cycle.
- No back-pressure. The downstream buffer overwrites on each done tick; a byte is lost if it was not consumed earlier.

## Timing

- Reset values:
  - `dout`=0, `rx_done_tick`=0, `frame_err`=0, `busy`=0.
  - FSM in IDLE, all counters 0, synchroniser=1.
- `rst` during any state returns everything to the reset values on the next edge. A partial frame is discarded with no pulses.
- Input latency: 2 clk from the `rx` edge to `rx_s`. Start detection adds 1 clk.
- Mid-bit sampling offset is 8 ticks ±1 tick of jitter plus 3 clk, from the true start edge.
- `rx_done_tick` / `frame_err` are registered and assert on the clk edge after the `s_tick` on which the stop bit is sampled. `dout` is valid in the same cycle as `rx_done_tick`.
- Frame duration is about (1 + DBIT)·16 + SB_TICK − 8 ticks. The receiver returns to IDLE half a stop bit before the line frame ends, so back-to-back frames with one stop bit are received without loss.
- Baud tolerance: ±3% cumulative over the frame.

## Structure

- Shared package `uart_pkg` holds:
  - the FSM state encoding (IDLE..BREAK) as localparams;
  - the default `DIV` and `SB_TICK` constants, shared with the TX side.
- Sub-module `uart_baud_gen` (parameter DIV; ports clk, rst, `tick`) is reused by the transmitter.
- The synchroniser and FSM live in `uart_rx_core`.

## Test plan

All scenarios use DIV=4, so one bit = 64 clk.
- Reset, then send 0xA5 (8N1): exactly one `rx_done_tick`, `dout`=0xA5, `frame_err` never high, `busy` low afterwards.
- Drive `rx` low for 3 ticks (12 clk) then high: no `rx_done_tick` or `frame_err`; FSM back in IDLE within 8 ticks.
- Send 0x3C with a low stop bit, then hold low 200 clk, then release: one `frame_err`, no done tick, `dout` keeps the prior 0xA5. A following 0x5A is received correctly.
- Back-to-back 0x00 then 0xFF with a single stop bit and no idle gap: two done pulses, `dout`=0x00 then 0xFF.
- Assert `rst` for 1 cycle in the middle of bit 4 of 0x81: no pulses and `dout`=0. After the line idles for one frame time, the next byte 0x42 is received correctly.
- Line at 3% faster baud (62 clk/bit), byte 0xC3: received as 0xC3.
